fifo_memory_ctrl_v2: RTL

Parametrised synchronous FIFO controller. It is the successor to the basic 8x8 FIFO, generalised in width and depth. It adds an occupancy count, programmable almost-full/almost-empty thresholds, sticky overflow/underflow error flags and a read-data-valid strobe. It sits between a single-clock producer and consumer as a rate-smoothing buffer, and it keeps the existing two-bit status vector st.

---
 rtl/fifo_memory_ctrl_v2.sv | 129 ++++++++++++
 1 files changed

// File: rtl/fifo_memory_ctrl_v2.sv
// ---------------------------------------------------------------------------
// fifo_memory_ctrl_v2
// Single-clock FIFO controller used as a rate-smoothing buffer between a
// producer and a consumer. Adds occupancy, almost-full/almost-empty
// thresholds, sticky error flags and a read-data-valid strobe on top of the
// basic FIFO.
//
// Ports:
//   clk          in   rising-edge system clock
//   rst          in   synchronous active-high reset
//   data_in      in   write data [DATA_SIZE]
//   WE           in   write request
//   RE           in   read request
//   clr_err      in   synchronous clear of overflow/underflow
//   data_out     out  registered read data [DATA_SIZE]
//   rd_valid     out  one-cycle strobe: data_out was just loaded
//   st           out  {empty, full}
//   count        out  occupancy 0..DEPTH [ADDR_SIZE+1]
//   almost_full  out  count >= AF_LEVEL
//   almost_empty out  count <= AE_LEVEL
//   overflow     out  sticky: write attempted while full and rejected
//   underflow    out  sticky: read attempted while empty
// ---------------------------------------------------------------------------
module fifo_memory_ctrl_v2 #(
  parameter int DATA_SIZE = 8,
  parameter int ADDR_SIZE = 3,
  parameter int DEPTH     = 8,
  parameter int AF_LEVEL  = 6,
  parameter int AE_LEVEL  = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [DATA_SIZE-1:0] data_in,
  input  logic                 WE,
  input  logic                 RE,
  input  logic                 clr_err,
  output logic [DATA_SIZE-1:0] data_out,
  output logic                 rd_valid,
  output logic [1:0]           st,
  output logic [ADDR_SIZE:0]   count,
  output logic                 almost_full,
  output logic                 almost_empty,
  output logic                 overflow,
  output logic                 underflow
);

  localparam logic [ADDR_SIZE:0] PTR_ONE_C   = (ADDR_SIZE+1)'(1);
  localparam logic [ADDR_SIZE:0] AF_LEVEL_C  = (ADDR_SIZE+1)'(AF_LEVEL);
  localparam logic [ADDR_SIZE:0] AE_LEVEL_C  = (ADDR_SIZE+1)'(AE_LEVEL);

  logic [DATA_SIZE-1:0] mem_r [DEPTH];
  logic [ADDR_SIZE:0]   wr_ptr_r;
  logic [ADDR_SIZE:0]   rd_ptr_r;
  logic [DATA_SIZE-1:0] data_out_r;
  logic                 rd_valid_r;
  logic                 overflow_r;
  logic                 underflow_r;

  logic                 empty_s;
  logic                 full_s;
  logic                 wr_ok_s;
  logic                 rd_ok_s;
  logic [ADDR_SIZE:0]   count_s;

  // Status decode from the registered pointers; MSB is the wrap bit.
  always_comb begin
    empty_s = (wr_ptr_r == rd_ptr_r);
    full_s  = (wr_ptr_r[ADDR_SIZE-1:0] == rd_ptr_r[ADDR_SIZE-1:0]) &&
              (wr_ptr_r[ADDR_SIZE] != rd_ptr_r[ADDR_SIZE]);
    count_s = wr_ptr_r - rd_ptr_r;
    rd_ok_s = RE & ~empty_s;
    // A read in the same cycle frees a slot, so a full FIFO still accepts.
    wr_ok_s = WE & (~full_s | rd_ok_s);
  end

  // Storage array; not reset, and writes are suppressed during reset.
  always_ff @(posedge clk) begin
    if (!rst && wr_ok_s) begin
      mem_r[wr_ptr_r[ADDR_SIZE-1:0]] <= data_in;
    end
  end

  // Pointers, read data path and sticky error flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_r    <= '0;
      rd_ptr_r    <= '0;
      data_out_r  <= '0;
      rd_valid_r  <= 1'b0;
      overflow_r  <= 1'b0;
      underflow_r <= 1'b0;
    end else begin
      if (wr_ok_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_ONE_C;
      end
      if (rd_ok_s) begin
        data_out_r <= mem_r[rd_ptr_r[ADDR_SIZE-1:0]];
        rd_ptr_r   <= rd_ptr_r + PTR_ONE_C;
        rd_valid_r <= 1'b1;
      end else begin
        rd_valid_r <= 1'b0;
      end
      // A new error in the same cycle as clr_err takes priority.
      if (WE && full_s && !rd_ok_s) begin
        overflow_r <= 1'b1;
      end else if (clr_err) begin
        overflow_r <= 1'b0;
      end
      if (RE && empty_s) begin
        underflow_r <= 1'b1;
      end else if (clr_err) begin
        underflow_r <= 1'b0;
      end
    end
  end

  // Output mapping; status outputs follow the pointers directly.
  always_comb begin
    data_out     = data_out_r;
    rd_valid     = rd_valid_r;
    st           = {empty_s, full_s};
    count        = count_s;
    almost_full  = (count_s >= AF_LEVEL_C);
    almost_empty = (count_s <= AE_LEVEL_C);
    overflow     = overflow_r;
    underflow    = underflow_r;
  end

endmodule
